// File: rtl/ttfir_pkg.sv
// Shared constants and types for the 4-tap FIR feeder: widths, tap count and sequencer states.
package ttfir_pkg;

    localparam int N_TAPS      = 4;
    localparam int BW_IN       = 6;
    localparam int IDX_W       = $clog2(N_TAPS);
    localparam int UFLOW_CNT_W = 8;

    typedef logic signed [BW_IN-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MODE   = 2'd1,
        LOAD   = 2'd2,
        STREAM = 2'd3
    } state_t;

endpackage

// File: rtl/ttfir_sample_fifo.sv
// Synchronous sample FIFO with a flush input. The head entry is always visible on data_o.
// flush wins over a same-cycle push, so that push is discarded.
module ttfir_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers are AW bits wide so they wrap naturally for power-of-two depths.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ttfir_feeder.sv
// Sequencer for the 4-tap FIR stage: mode word, coefficients (h[N-1] first), then paced samples.
// Optional TTFIR_FEEDER_UFLOW_CNT_EN adds a saturating underflow counter output.
module ttfir_feeder
    import ttfir_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cfg_lsb_i,
    input  logic             coef_we_i,
    input  logic [IDX_W-1:0] coef_addr_i,
    input  sample_t          coef_data_i,
    // Sample source: a beat transfers on a rising edge where s_valid_i && s_ready_o.
    input  logic             s_valid_i,
    input  sample_t          s_data_i,
    output logic             s_ready_o,
    output logic             fir_reset_o,
    output sample_t          fir_x_o,
    output logic             busy_o,
    output logic             underflow_o,
`ifdef TTFIR_FEEDER_UFLOW_CNT_EN
    output logic [UFLOW_CNT_W-1:0] uflow_cnt_o,
`endif
    output state_t           dbg_state_o
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_q, slot_d;
    logic             lsb_q, lsb_d;
    logic             fir_reset_q, fir_reset_d;
    sample_t          fir_x_q, fir_x_d;
    logic             underflow_q, underflow_d;
    sample_t          coef_q [N_TAPS];

    logic    fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic    slot_act, start_acc;
    sample_t fifo_head;

    ttfir_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BW_IN)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (s_data_i),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s_ready_o = !fifo_full;
    assign fifo_push = s_valid_i && s_ready_o;

    // Output registers are loaded with the value for the cycle being entered, so
    // fir_x_o/fir_reset_o always match the state shown on dbg_state_o.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        slot_d      = slot_q;
        lsb_d       = lsb_q;
        fir_reset_d = 1'b1;
        fir_x_d     = '0;
        underflow_d = underflow_q;
        fifo_pop    = 1'b0;
        fifo_flush  = 1'b0;
        slot_act    = 1'b0;
        start_acc   = 1'b0;
        if (stop_i) begin
            state_d    = IDLE;
            fifo_flush = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        start_acc   = 1'b1;
                        state_d     = MODE;
                        lsb_d       = cfg_lsb_i;
                        underflow_d = 1'b0;
                        fir_reset_d = 1'b0;
                        fir_x_d[0]  = cfg_lsb_i;
                    end
                end
                MODE: begin
                    state_d     = LOAD;
                    fir_reset_d = 1'b0;
                    idx_d       = IDX_W'(N_TAPS - 1);
                    fir_x_d     = coef_q[N_TAPS-1];
                end
                LOAD: begin
                    fir_reset_d = 1'b0;
                    if (idx_q == '0) begin
                        // The FIR's read flag resets to 1, so the first STREAM cycle is a slot.
                        state_d  = STREAM;
                        slot_act = 1'b1;
                        slot_d   = !lsb_q;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        fir_x_d = coef_q[idx_q - IDX_W'(1)];
                    end
                end
                STREAM: begin
                    fir_reset_d = 1'b0;
                    slot_act    = slot_q;
                    slot_d      = lsb_q ? !slot_q : 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
        if (slot_act) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                fir_x_d  = fifo_head;
            end else begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            slot_q      <= 1'b1;
            lsb_q       <= 1'b0;
            fir_reset_q <= 1'b1;
            fir_x_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            slot_q      <= slot_d;
            lsb_q       <= lsb_d;
            fir_reset_q <= fir_reset_d;
            fir_x_q     <= fir_x_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_TAPS; k++) coef_q[k] <= '0;
        end else if (state_q == IDLE && coef_we_i) begin
            coef_q[coef_addr_i] <= coef_data_i;
        end
    end

`ifdef TTFIR_FEEDER_UFLOW_CNT_EN
    logic [UFLOW_CNT_W-1:0] uflow_cnt_q, uflow_cnt_d;

    always_comb begin
        uflow_cnt_d = uflow_cnt_q;
        if (start_acc) begin
            uflow_cnt_d = '0;
        end else if (slot_act && fifo_empty && uflow_cnt_q != '1) begin
            uflow_cnt_d = uflow_cnt_q + UFLOW_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) uflow_cnt_q <= '0;
        else       uflow_cnt_q <= uflow_cnt_d;
    end

    assign uflow_cnt_o = uflow_cnt_q;
`endif

    assign fir_reset_o = fir_reset_q;
    assign fir_x_o     = fir_x_q;
    assign busy_o      = (state_q != IDLE);
    assign underflow_o = underflow_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ttfir_feeder.sv
// Bench for ttfir_feeder: directed vector table, hand sequences for stop/reset/backpressure,
// and randomized loads checked against a queue-based model of the feeder's output stream.
module tb_ttfir_feeder;
    import ttfir_pkg::*;

    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start, stop, cfg_lsb, coef_we, s_valid;
    logic [IDX_W-1:0] coef_addr;
    sample_t          coef_data, s_data;
    logic             s_ready, fir_reset, busy, underflow;
    sample_t          fir_x;
    state_t           dbg_state;
`ifdef TTFIR_FEEDER_UFLOW_CNT_EN
    logic [7:0]       uflow_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ttfir_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_i     (start),
        .stop_i      (stop),
        .cfg_lsb_i   (cfg_lsb),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .s_valid_i   (s_valid),
        .s_data_i    (s_data),
        .s_ready_o   (s_ready),
        .fir_reset_o (fir_reset),
        .fir_x_o     (fir_x),
        .busy_o      (busy),
        .underflow_o (underflow),
`ifdef TTFIR_FEEDER_UFLOW_CNT_EN
        .uflow_cnt_o (uflow_cnt),
`endif
        .dbg_state_o (dbg_state)
    );

    typedef struct {
        logic             lsb;
        logic [0:3][5:0]  h;      // h[k] is coefficient k
        int               nsamp;
        logic [0:3][5:0]  samp;
        logic [0:11][5:0] exp_x;  // mode word, 4 coefficients, 7 stream cycles
        logic             exp_uf;
        int               exp_cnt;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int k, input logic [5:0] v);
        coef_we = 1'b1; coef_addr = IDX_W'(k); coef_data = v;
        step();
        coef_we = 1'b0;
    endtask

    task automatic push_sample(input logic [5:0] v);
        s_valid = 1'b1; s_data = v;
        step();
        s_valid = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic check_uflow_cnt(input string name, input int exp);
`ifdef TTFIR_FEEDER_UFLOW_CNT_EN
        check(name, int'(uflow_cnt), exp);
`endif
    endtask

    function automatic int sx(input logic [5:0] v);
        return int'(sample_t'(v));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_q[$];
        logic [5:0] hr[4];
        logic [5:0] ex, d;
        logic       lsb, v, rdy, slot;
        int         nk, uf;
        int         seq[6];

        reset = 1'b1; start = 0; stop = 0; cfg_lsb = 0; coef_we = 0;
        coef_addr = '0; coef_data = '0; s_valid = 0; s_data = '0;

        vecs[0] = '{1'b0, {6'd1, 6'd2, 6'd3, 6'd4}, 4, {6'd5, 6'(-3), 6'd7, 6'd1},
                    {6'd0, 6'd4, 6'd3, 6'd2, 6'd1, 6'd5, 6'(-3), 6'd7, 6'd1, 6'd0, 6'd0, 6'd0}, 1'b1, 3};
        vecs[1] = '{1'b1, {6'd1, 6'd2, 6'd3, 6'd4}, 3, {6'd10, 6'd11, 6'd12, 6'd0},
                    {6'd1, 6'd4, 6'd3, 6'd2, 6'd1, 6'd10, 6'd0, 6'd11, 6'd0, 6'd12, 6'd0, 6'd0}, 1'b1, 1};
        vecs[2] = '{1'b0, {6'(-32), 6'd31, 6'd0, 6'(-1)}, 0, {6'd0, 6'd0, 6'd0, 6'd0},
                    {6'd0, 6'(-1), 6'd0, 6'd31, 6'(-32), 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, 1'b1, 7};
        vecs[3] = '{1'b1, {6'd7, 6'(-7), 6'd15, 6'(-16)}, 4, {6'(-1), 6'(-2), 6'(-3), 6'(-4)},
                    {6'd1, 6'(-16), 6'd15, 6'(-7), 6'd7, 6'(-1), 6'd0, 6'(-2), 6'd0, 6'(-3), 6'd0, 6'(-4)}, 1'b0, 0};

        // Reset values
        step(); step();
        check("rst_fir_reset", int'(fir_reset), 1);
        check("rst_fir_x", int'(fir_x), 0);
        check("rst_s_ready", int'(s_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_underflow", int'(underflow), 0);
        check("rst_state", int'(dbg_state), int'(IDLE));
        check_uflow_cnt("rst_uflow_cnt", 0);
        reset = 1'b0;
        step();

        // Directed vector table
        for (int n = 0; n < 4; n++) begin
            do_stop();
            for (int k = 0; k < 4; k++) write_coef(k, vecs[n].h[k]);
            for (int k = 0; k < vecs[n].nsamp; k++) push_sample(vecs[n].samp[k]);
            cfg_lsb = vecs[n].lsb;
            start = 1'b1;
            step();
            start = 1'b0;
            check("vec_fir_reset_low", int'(fir_reset), 0);
            check("vec_busy", int'(busy), 1);
            for (int i = 0; i < 12; i++) begin
                if (i > 0) step();
                check($sformatf("vec%0d_x%0d", n, i), sx(fir_x), sx(vecs[n].exp_x[i]));
            end
            check($sformatf("vec%0d_underflow", n), int'(underflow), int'(vecs[n].exp_uf));
            check_uflow_cnt($sformatf("vec%0d_uflow_cnt", n), vecs[n].exp_cnt);
        end

        // Stop mid-stream: FIFO flushed, same-cycle push dropped, coefficients kept
        do_stop();
        for (int k = 0; k < 4; k++) write_coef(k, 6'(k + 1));
        push_sample(6'd5);
        push_sample(6'(-3));
        cfg_lsb = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check("stop_pre_x", sx(fir_x), 5);
        stop = 1'b1; s_valid = 1'b1; s_data = 6'd9;
        step();
        stop = 1'b0; s_valid = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_fir_reset", int'(fir_reset), 1);
        check("stop_fir_x", int'(fir_x), 0);
        check("stop_s_ready", int'(s_ready), 1);
        seq = '{0, 4, 3, 2, 1, 0};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            check($sformatf("restart_x%0d", i), sx(fir_x), seq[i]);
            if (i == 1) begin
                // Writes and starts while busy must have no effect
                coef_we = 1'b1; coef_addr = '0; coef_data = 6'd31; start = 1'b1;
            end else begin
                coef_we = 1'b0; start = 1'b0;
            end
        end
        check("restart_underflow", int'(underflow), 1);
        check_uflow_cnt("restart_uflow_cnt", 1);

        // Reset mid-LOAD clears coefficients
        do_stop();
        start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        check("mid_load_state", int'(dbg_state), int'(LOAD));
        reset = 1'b1;
        step();
        check("midrst_fir_reset", int'(fir_reset), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_underflow", int'(underflow), 0);
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check($sformatf("midrst_x%0d", i), sx(fir_x), 0);
        end

        // Backpressure: 5th sample waits for the first STREAM pop
        do_stop();
        for (int k = 0; k < 4; k++) write_coef(k, 6'(k + 1));
        for (int k = 0; k < 4; k++) push_sample(6'(20 + k));
        check("bp_full_ready", int'(s_ready), 0);
        s_valid = 1'b1; s_data = 6'd24; cfg_lsb = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        check("bp_hold_ready", int'(s_ready), 0);
        step();
        check("bp_x0", sx(fir_x), 20);
        check("bp_ready_after_pop", int'(s_ready), 1);
        step();
        s_valid = 1'b0;
        for (int i = 1; i < 6; i++) begin
            if (i > 1) step();
            check($sformatf("bp_x%0d", i), sx(fir_x), (i < 5) ? 20 + i : 0);
        end
        check("bp_underflow", int'(underflow), 1);

        // Randomized loads against the queue model
        for (int it = 0; it < 20; it++) begin
            do_stop();
            exp_q.delete();
            lsb = 1'($urandom_range(0, 1));
            for (int k = 0; k < 4; k++) begin
                hr[k] = 6'($urandom_range(0, 63));
                write_coef(k, hr[k]);
            end
            nk = $urandom_range(0, DEPTH);
            for (int k = 0; k < nk; k++) begin
                d = 6'($urandom_range(0, 63));
                push_sample(d);
                exp_q.push_back(d);
            end
            cfg_lsb = lsb;
            start = 1'b1;
            step();
            start = 1'b0;
            check("rnd_mode", int'(fir_x), int'(lsb));
            for (int k = 3; k >= 0; k--) begin
                step();
                check("rnd_coef", sx(fir_x), sx(hr[k]));
            end
            uf = 0;
            for (int j = 0; j < 14; j++) begin
                v = ($urandom_range(0, 2) == 0);
                d = 6'($urandom_range(0, 63));
                s_valid = v; s_data = d;
                rdy  = (exp_q.size() < DEPTH);
                slot = !lsb || (j % 2 == 0);
                ex = '0;
                if (slot) begin
                    if (exp_q.size() > 0) ex = exp_q.pop_front();
                    else uf++;
                end
                if (v && rdy) exp_q.push_back(d);
                step();
                check("rnd_stream_x", sx(fir_x), sx(ex));
                check("rnd_s_ready", int'(s_ready), int'(exp_q.size() < DEPTH));
            end
            s_valid = 1'b0;
            check("rnd_underflow", int'(underflow), int'(uf > 0));
            check_uflow_cnt("rnd_uflow_cnt", (uf > 255) ? 255 : uf);
        end

        do_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttfir_feeder.md
Name: ttfir_feeder

Overview:
- Upstream sequencer for the 4-tap FIR stage; drives that stage's `reset` and 6-bit `x_in` pins.
- After `start`, it emits three things in order: the output-mode word (LSB-readout flag), then the N_TAPS coefficients, then a continuous sample stream.
- Samples come from a valid/ready source and are buffered in a small FIFO.
- It paces sample delivery to the FIR's consume slots: every cycle in MSB-only mode, every other cycle in LSB mode.

Parameters:
- N_TAPS, 4, number of FIR coefficients sent per load.
- BW_IN, 6, sample and coefficient width.
- FIFO_DEPTH, 4, sample FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; honoured only in IDLE.
- stop  in  1  returns to IDLE from any state; takes priority over start.
- cfg_lsb  in  1  LSB readout mode; sampled when start is accepted.
- coef_we  in  1  coefficient write strobe; honoured only in IDLE.
- coef_addr  in  $clog2(N_TAPS)  tap index k.
- coef_data  in  BW_IN  signed coefficient h[k].
- s_valid  in  1  sample source valid.
- s_data  in  BW_IN  signed sample.
- s_ready  out  1  = FIFO not full (no full-pop bypass).
- fir_reset  out  1  registered; drives FIR reset.
- fir_x  out  BW_IN  registered; drives FIR x_in.
- busy  out  1  state != IDLE.
- underflow  out  1  sticky; set when a sample slot finds the FIFO empty; cleared by reset or start.

Behaviour:
- Reset:
  - state=IDLE, fir_reset=1, fir_x=0, busy=0, underflow=0.
  - Coefficient regs cleared to 0; FIFO emptied; mode reg=0.
- Output timing: all outputs are registered; the FIR samples them on the following edge.
- IDLE:
  - fir_reset=1, fir_x=0.
  - coef_we writes coef[coef_addr] <= coef_data.
  - start → MODE: latch cfg_lsb, clear underflow.
- MODE (1 cycle): fir_reset=0, fir_x={0…,lsb}; the FIR uses only bit 0. → LOAD with idx=N_TAPS-1.
- LOAD (N_TAPS cycles):
  - fir_x=coef[idx]; idx decrements.
  - h[N_TAPS-1] is sent first and h[0] last, so h[k] lands in FIR tap k (h[0] multiplies the newest sample).
  - After idx=0 → STREAM with slot=1.
- STREAM:
  - Slot cycle (slot=1): if FIFO is non-empty, pop and fir_x=head. Otherwise fir_x=0 and underflow<=1.
  - Non-slot cycle: fir_x=0 (ignored by the FIR), no pop.
  - Slot update: if lsb, slot toggles each cycle; else slot stays 1.
  - The first STREAM cycle is always a slot (the FIR's read flag resets to 1).
- FIFO:
  - Push when s_valid && s_ready; this holds in every state, including IDLE, so samples can be pre-buffered.
  - Pop only in STREAM slot cycles.
  - Push and pop in the same cycle on a non-empty FIFO: both happen, count unchanged.
  - Push into an empty FIFO in a slot cycle: no bypass. The slot underflows; the pushed data becomes the next head.
  - Pointers wrap modulo FIFO_DEPTH.
- stop (any state):
  - Next state IDLE, fir_reset=1 next cycle, FIFO flushed.
  - A same-cycle push is discarded.
  - Coefficients are retained.
- reset mid-LOAD/STREAM: same as the reset values above; coefficients cleared.
- start while busy is ignored.
- coef_we while busy is ignored.

Optional Feature:
- Macro: TTFIR_FEEDER_UFLOW_CNT_EN.
- Defined:
  - Adds output uflow_cnt [7:0]: saturating (at 255) count of underflowed slots.
  - Cleared on reset and on accepted start.
- Undefined: port absent; only the sticky underflow flag exists.

Decomposition:
- Package ttfir_pkg:
  - Constants N_TAPS=4, BW_IN=6.
  - State enum {IDLE, MODE, LOAD, STREAM}.
  - Signed sample/coefficient typedef.
- Sub-module ttfir_sample_fifo: synchronous FIFO with push/pop/full/empty/flush; parameterised by depth and width.

Test Plan:
- Reset: reset high 2 cycles → fir_reset=1, fir_x=0, s_ready=1, busy=0, underflow=0.
- Load sequence:
  - Stimulus: write coef 0..3 = 1,2,3,4, set cfg_lsb=0, pulse start.
  - fir_x sequence after start: 0 (mode), 4, 3, 2, 1.
  - fir_reset falls in the cycle after start.
- MSB mode streaming:
  - Stimulus: pre-buffer samples 5, -3, 7, 1.
  - fir_x carries 5, -3, 7, 1 on 4 consecutive STREAM cycles, then 0 with underflow=1.
- LSB mode pacing:
  - Stimulus: cfg_lsb=1, FIFO kept non-empty with 10, 11, 12.
  - Mode cycle drives 1.
  - STREAM fir_x: 10, 0, 11, 0, 12; pops occur only in slot cycles.
- Backpressure:
  - Stimulus: FIFO_DEPTH=4, s_valid held high in IDLE.
  - s_ready drops after 4 pushes; a 5th sample is held by the source and accepted after the first STREAM pop.
- Stop and reset mid-stream:
  - stop in STREAM → IDLE next cycle, fir_reset=1, FIFO empty, coefficients retained: a restart re-sends 4, 3, 2, 1.
  - reset mid-LOAD → a restart sends 0, 0, 0, 0.
